// File: rtl/audio_i2s_tx.sv
// I2S audio transmitter: divides AUDIO_CLK into BCLK and shifts out {L,R} frames MSB first
// with a one-slot delay. A single-entry holding buffer decouples sample delivery from frames.
module audio_i2s_tx #(
    parameter int AUD_BIT_DEPTH = 32,
    parameter int BCLK_DIV      = 4
) (
    input  logic                     AUDIO_CLK,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
    input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic                     AUD_BCLK,
    output logic                     AUD_DACLRCK,
    output logic                     AUD_DACDAT,
    output logic                     frame_start,
    output logic [15:0]              underrun_cnt
);
    localparam int D  = AUD_BIT_DEPTH;
    localparam int FW = 2 * D;
    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(FW);
    localparam logic [DW-1:0] DIV_LAST   = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF   = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] SLOT_LAST  = BW'(FW - 1);
    localparam logic [BW-1:0] SLOT_RIGHT = BW'(D);

    logic [DW-1:0] div_cnt, div_next;
    logic [BW-1:0] bit_cnt, bit_next;
    logic [FW-1:0] shifter, load_word;
    logic [D-1:0]  buf_l, buf_r;
    logic          buf_full;
    logic          div_wrap, load;
    logic [15:0]   underrun_q;

    always_comb begin
        div_wrap  = (div_cnt == DIV_LAST);
        load      = enable && div_wrap && (bit_cnt == SLOT_LAST);
        div_next  = div_wrap ? '0 : div_cnt + 1'b1;
        bit_next  = bit_cnt;
        if (div_wrap)
            bit_next = (bit_cnt == SLOT_LAST) ? '0 : bit_cnt + 1'b1;
        // Buffered sample wins; otherwise a sample arriving on the load cycle bypasses the buffer.
        load_word = '0;
        if (buf_full)
            load_word = {buf_l, buf_r};
        else if (sample_valid)
            load_word = {lsound_in, rsound_in};
    end

    assign sample_ready = !buf_full && !reset;
    assign underrun_cnt = underrun_q;

    always_ff @(posedge AUDIO_CLK) begin
        if (reset || !enable) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            shifter     <= '0;
            AUD_BCLK    <= 1'b0;
            AUD_DACLRCK <= 1'b0;
            AUD_DACDAT  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_next;
            bit_cnt     <= bit_next;
            AUD_BCLK    <= (div_next >= DIV_HALF);
            frame_start <= load;
            // Serial outputs move only on the BCLK falling edge; the MSB of the shifter
            // is one slot behind the slot counter, which gives the I2S delay for free.
            if (div_wrap) begin
                AUD_DACDAT  <= shifter[FW-1];
                AUD_DACLRCK <= (bit_next >= SLOT_RIGHT);
                shifter     <= load ? load_word : {shifter[FW-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge AUDIO_CLK) begin
        if (reset) begin
            buf_full   <= 1'b0;
            buf_l      <= '0;
            buf_r      <= '0;
            underrun_q <= '0;
        end else if (load) begin
            if (buf_full)
                buf_full <= 1'b0;
            else if (!sample_valid && underrun_q != 16'hFFFF)
                underrun_q <= underrun_q + 16'd1;
        end else if (sample_valid && !buf_full) begin
            buf_l    <= lsound_in;
            buf_r    <= rsound_in;
            buf_full <= 1'b1;
        end
    end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: a frame monitor checks every serialised frame against a scoreboard
// of expected words; a vector table plus hand-written sequences drive the corner cases.
module tb_audio_i2s_tx;
    localparam int D     = 32;
    localparam int DIV   = 4;
    localparam int FRAME = DIV * 2 * D;

    logic        clk = 1'b0;
    logic        reset, enable, sample_valid;
    logic [31:0] l_in, r_in;
    logic        sample_ready, aud_bclk, aud_lrck, aud_dat, frame_start;
    logic [15:0] underrun_cnt;

    always #5 clk = ~clk;

    audio_i2s_tx #(.AUD_BIT_DEPTH(D), .BCLK_DIV(DIV)) dut (
        .AUDIO_CLK(clk), .reset(reset), .enable(enable),
        .lsound_in(l_in), .rsound_in(r_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .AUD_BCLK(aud_bclk), .AUD_DACLRCK(aud_lrck),
        .AUD_DACDAT(aud_dat), .frame_start(frame_start), .underrun_cnt(underrun_cnt)
    );

    typedef struct { logic [63:0] word; logic [15:0] under; } exp_t;
    typedef struct { bit push; bit at_load; logic [31:0] l; logic [31:0] r; logic [15:0] exp_under; } vec_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   n_checks = 0;
    int   n_pass = 0;
    int   mon_gen = 0;
    bit   mon_en = 1'b0;
    bit   prev_valid = 1'b0;
    bit   at_fs = 1'b0;
    logic prev_bit0 = 1'b0;

    function automatic exp_t mk(input logic [63:0] w, input logic [15:0] u);
        exp_t e;
        e.word  = w;
        e.under = u;
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        if (at_fs) begin
            at_fs = 1'b0;
            return;
        end
        do begin
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < 2 * FRAME);
        if (frame_start !== 1'b1) begin
            n_checks++;
            $display("FAIL fs_timeout: no frame_start after %0d cycles", n);
        end
    endtask

    task automatic push_one(input logic [31:0] l, input logic [31:0] r);
        l_in = l;
        r_in = r;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    // Frame monitor: slot k sampled mid-slot (div_cnt==2); slot 0 carries the previous word's LSB.
    initial begin : monitor
        exp_t        e;
        logic [63:0] got, got_lr;
        int          bclk_bad, gen;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (mon_en && frame_start === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_empty: frame_start with no expected frame");
                end else begin
                    e = sb.pop_front();
                    gen = mon_gen;
                    check("frame_underrun", underrun_cnt, e.under);
                    got = '0; got_lr = '0; bclk_bad = 0; aborted = 1'b0;
                    for (int c = 0; c < FRAME - 1; c++) begin
                        if (c > 0) @(negedge clk);
                        if (!mon_en || gen != mon_gen) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (aud_bclk !== ((c % DIV) >= DIV / 2)) bclk_bad++;
                        if (c % DIV == 2) begin
                            got_lr[c / DIV] = aud_lrck;
                            if (c / DIV == 0) begin
                                if (prev_valid) check("slot0_prev_lsb", aud_dat, prev_bit0);
                            end else begin
                                got[64 - c / DIV] = aud_dat;
                            end
                        end
                    end
                    if (!aborted) begin
                        check("frame_word", {got[63:1], 1'b0}, {e.word[63:1], 1'b0});
                        check("frame_lrck", got_lr, 64'hFFFFFFFF_00000000);
                        check("frame_bclk", bclk_bad, 0);
                        prev_bit0  = e.word[0];
                        prev_valid = 1'b1;
                    end else begin
                        prev_valid = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : stim
        int n, bad;
        tbl[0] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 16'd0};
        tbl[1] = '{1'b0, 1'b0, 32'h0,        32'h0,        16'd1};
        tbl[2] = '{1'b0, 1'b0, 32'h0,        32'h0,        16'd2};
        tbl[3] = '{1'b0, 1'b0, 32'h0,        32'h0,        16'd3};
        tbl[4] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000000, 16'd3};
        tbl[5] = '{1'b1, 1'b0, 32'h12345678, 32'h9ABCDEF0, 16'd3};
        tbl[6] = '{1'b1, 1'b0, 32'h5A5A5A5A, 32'hA5A5A5A5, 16'd3};
        tbl[7] = '{1'b0, 1'b0, 32'h0,        32'h0,        16'd4};

        reset = 1'b1; enable = 1'b1; sample_valid = 1'b0; l_in = '0; r_in = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_outputs_%0d", i),
                  {aud_bclk, aud_lrck, aud_dat, frame_start, sample_ready, underrun_cnt}, '0);
        end
        reset = 1'b0;
        mon_en = 1'b1;
        #1 check("ready_after_release", sample_ready, 1'b1);

        sb.push_back(mk({32'h80000001, 32'h7FFFFFFE}, 16'd0));
        push_one(32'h80000001, 32'h7FFFFFFE);
        wait_fs(n);
        check("first_fs_latency", n + 1, FRAME);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].push && !tbl[i].at_load) begin
                check($sformatf("ready_before_push_%0d", i), sample_ready, 1'b1);
                sb.push_back(mk({tbl[i].l, tbl[i].r}, tbl[i].exp_under));
                push_one(tbl[i].l, tbl[i].r);
            end else if (tbl[i].push) begin
                repeat (FRAME - 1) tick();
                sb.push_back(mk({tbl[i].l, tbl[i].r}, tbl[i].exp_under));
                push_one(tbl[i].l, tbl[i].r);
                check("bypass_fs", frame_start, 1'b1);
                check("bypass_buf_empty", sample_ready, 1'b1);
                at_fs = 1'b1;
            end else begin
                sb.push_back(mk(64'd0, tbl[i].exp_under));
            end
            wait_fs(n);
        end

        // Buffer full while a second sample is held valid.
        check("ready_empty_buf", sample_ready, 1'b1);
        sb.push_back(mk({32'hCAFEF00D, 32'h0BADBEEF}, 16'd4));
        push_one(32'hCAFEF00D, 32'h0BADBEEF);
        l_in = 32'h13579BDF; r_in = 32'h2468ACE0; sample_valid = 1'b1;
        n = 0; bad = 0;
        do begin
            if (sample_ready !== 1'b0) bad++;
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < 2 * FRAME);
        check("ready_low_while_full", bad, 0);
        check("held_fs_seen", frame_start, 1'b1);
        check("ready_after_load", sample_ready, 1'b1);
        sb.push_back(mk({32'h13579BDF, 32'h2468ACE0}, 16'd4));
        tick();
        check("held_sample_captured", sample_ready, 1'b0);
        sample_valid = 1'b0;
        wait_fs(n);
        sb.push_back(mk(64'd0, 16'd5));
        wait_fs(n);
        check("underrun_after_hold", underrun_cnt, 16'd5);

        // Saturation: preset the counter near full.
        force dut.underrun_q = 16'hFFFE;
        tick();
        release dut.underrun_q;
        check("underrun_preset", underrun_cnt, 16'hFFFE);
        sb.push_back(mk(64'd0, 16'hFFFF));
        wait_fs(n);
        sb.push_back(mk(64'd0, 16'hFFFF));
        wait_fs(n);
        check("underrun_saturated", underrun_cnt, 16'hFFFF);

        // Reset mid-frame (bit_cnt 20) with a buffered sample.
        push_one(32'hDEADBEEF, 32'hFEEDFACE);
        repeat (20 * DIV - 1) tick();
        mon_en = 1'b0;
        mon_gen++;
        reset = 1'b1;
        tick();
        check("midframe_reset_outputs",
              {aud_bclk, aud_lrck, aud_dat, frame_start, sample_ready, underrun_cnt}, '0);
        reset = 1'b0;
        sb.delete();
        prev_valid = 1'b0;
        #1 check("reset_discards_buffer", sample_ready, 1'b1);
        sb.push_back(mk(64'd0, 16'd1));
        mon_en = 1'b1;
        wait_fs(n);
        check("post_reset_fs_latency", n, FRAME);
        check("post_reset_underrun", underrun_cnt, 16'd1);

        // enable low: timing held, buffer and counter retained.
        tick();
        mon_en = 1'b0;
        mon_gen++;
        enable = 1'b0;
        tick();
        check("disabled_outputs_zero", {aud_bclk, aud_lrck, aud_dat, frame_start}, '0);
        check("disabled_underrun_kept", underrun_cnt, 16'd1);
        check("ready_while_disabled", sample_ready, 1'b1);
        push_one(32'h0F0F0F0F, 32'hF0F0F0F0);
        check("capture_while_disabled", sample_ready, 1'b0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if ({aud_bclk, aud_lrck, aud_dat, frame_start} !== 4'b0) bad++;
            tick();
        end
        check("disabled_quiet", bad, 0);
        enable = 1'b1;
        prev_valid = 1'b0;
        sb.push_back(mk({32'h0F0F0F0F, 32'hF0F0F0F0}, 16'd1));
        mon_en = 1'b1;
        wait_fs(n);
        check("enable_restart_latency", n, FRAME);
        sb.push_back(mk(64'd0, 16'd2));
        wait_fs(n);
        check("final_underrun", underrun_cnt, 16'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter AUD_BIT_DEPTH, default 32: sample width per channel (D).
REQ-002 SHALL have parameter BCLK_DIV, default 4: AUDIO_CLK cycles per BCLK period; even, >=2.
REQ-003 SHALL have port AUDIO_CLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  high = run bit timing; low = timing held in reset state.
REQ-006 SHALL have port lsound_in  input  D  left sample, two's complement.
REQ-007 SHALL have port rsound_in  input  D  right sample, two's complement.
REQ-008 SHALL have port sample_valid  input  1  lsound_in/rsound_in valid.
REQ-009 SHALL have port sample_ready  output  1  block accepts a sample this cycle.
REQ-010 SHALL have port AUD_BCLK  output  1  serial bit clock.
REQ-011 SHALL have port AUD_DACLRCK  output  1  word select; 0 = left, 1 = right; also the synth frame trigger.
REQ-012 SHALL have port AUD_DACDAT  output  1  serial data, MSB first, I2S one-slot delay.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse when a frame word is loaded.
REQ-014 SHALL have port underrun_cnt  output  16  saturating count of frames loaded with no sample.

Function
REQ-015 div_cnt SHALL count 0..BCLK_DIV-1 and wrap; bit_cnt (0..2D-1) SHALL advance by 1, wrapping, on each div_cnt wrap.
REQ-016 AUD_BCLK SHALL be registered, 0 while div_cnt < BCLK_DIV/2, else 1; all other serial outputs change only in cycles where div_cnt==0 (BCLK falling edge).
REQ-017 AUD_DACLRCK SHALL be 0 for slots bit_cnt 0..D-1 and 1 for D..2D-1.
REQ-018 Load event: cycle with div_cnt==BCLK_DIV-1 and bit_cnt==2D-1; on it the shifter SHALL load {L,R} (2D bits) and frame_start SHALL be 1 in the following cycle.
REQ-019 AUD_DACDAT in slot k>=1 SHALL equal bit (2D-k) of the current frame word; in slot 0 it SHALL equal the previous frame's R LSB (bit 0).
REQ-020 Single-entry holding buffer: sample_ready = !buf_full && !reset; valid&&ready SHALL capture both channels and set buf_full.
REQ-021 Load with buf_full SHALL load the buffer and clear buf_full; sample_ready SHALL be 1 from the next cycle.
REQ-022 Load with buffer empty and sample_valid=1 in the same cycle SHALL bypass: the input is loaded directly, buf_full stays 0, no underrun is counted.
REQ-023 Load with buffer empty and sample_valid=0 SHALL load all zeros (mute) and increment underrun_cnt, saturating at 16'hFFFF.
REQ-024 enable=0 SHALL force div_cnt, bit_cnt, shifter, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_start to 0; buffer and underrun_cnt SHALL be retained; no load events occur.
REQ-025 On enable rising, timing SHALL restart at slot 0, div_cnt 0; the first load event occurs BCLK_DIV*2D-1 cycles later.

Reset
REQ-026 reset SHALL clear div_cnt, bit_cnt, shifter, buf_full, underrun_cnt and drive AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_start, sample_ready to 0 in the next cycle, overriding every other input.
REQ-027 reset asserted mid-frame SHALL discard the in-flight frame and any buffered sample; after release, behaviour SHALL match a power-on start (REQ-025 timing).

Verification
REQ-028 Reset 3 cycles, enable=1 -> all outputs 0 during reset; sample_ready=1 first cycle after release; first frame_start 256 cycles after release (defaults).
REQ-029 Push L=32'h80000001, R=32'h7FFFFFFE before first load -> next frame: slot1 DAT=1, slots 2..31 = 0, slot32 DAT=1 with LRCK=1, slot33 = 0, slots 34..63 = 1, next slot0 = 0.
REQ-030 No sample ever -> DAT constantly 0, underrun_cnt 1,2,3 after successive frame_starts; with counter preset/forced to 16'hFFFE, two more underruns -> holds 16'hFFFF.
REQ-031 Buffer full, second sample_valid held -> sample_ready=0 until the cycle after frame_start, then captured; no underrun counted.
REQ-032 Buffer empty, sample_valid=1 exactly on the load cycle with L=32'hFFFFFFFF -> that frame's slots 1..32 = 1, buf_full stays 0, underrun_cnt unchanged.
REQ-033 reset pulsed at bit_cnt 20 with a buffered sample -> outputs 0, buffer empty, next frame_start 256 cycles after release, underrun_cnt=1 on that frame.
